// File: rtl/ttl_sync_fifo.sv
// ---------------------------------------------------------------------------
// TtlSyncFifo (module ttl_sync_fifo)
//
// Purpose:
//    Small single-clock first-word-fall-through FIFO used to queue words
//    captured off the remote TTL bus. The head word is presented
//    combinationally whenever the FIFO is non-empty. While the FIFO is empty
//    the output is forced to zero, so nothing stale is ever shown.
//
// Parameters:
//    DATA_W  width of each stored word
//    DEPTH   number of entries, power of two, at least 2
//
// Ports:
//    clk         single clock for all state
//    reset       synchronous active-high reset (pointers and level to 0)
//    push_i      write request; dropped when full unless pop_i is also high
//    pushData_i  word written on an accepted push
//    pop_i       read request; ignored while empty
//    popData_o   head word (zero while empty)
//    level_o     current occupancy, 0..DEPTH
//    full_o      occupancy equals DEPTH
//    empty_o     occupancy equals 0
// ---------------------------------------------------------------------------
module ttl_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        pushData_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        popData_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wrPtr_q;
   logic [PTR_W-1:0]  wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q;
   logic [PTR_W-1:0]  rdPtr_d;
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  level_d;
   logic              pushOk;
   logic              popOk;

   // Status flags come straight from the occupancy counter. A push while full
   // is still accepted when a pop retires the head in the same cycle, because
   // the slot being written is the one being freed. A pop only counts when
   // there is something to pop.
   always_comb begin
      full_o  = (level_q == LVL_W'(DEPTH));
      empty_o = (level_q == '0);
      pushOk  = push_i && (!full_o || pop_i);
      popOk   = pop_i && !empty_o;
   end

   // Next-state for pointers and level. The pointers are exactly PTR_W bits
   // wide and DEPTH is a power of two, so the increments wrap modulo DEPTH on
   // their own. Level changes only when exactly one of push/pop is accepted.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (pushOk) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popOk) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (pushOk && !popOk) begin
         level_d = level_q + LVL_W'(1);
      end else if (popOk && !pushOk) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   // Control registers, cleared by the synchronous reset. Any words still in
   // the array become unreachable once the pointers and level return to 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   // Storage array. It is written only on an accepted push and needs no reset,
   // because the read side is gated by the empty flag.
   always_ff @(posedge clk) begin
      if (pushOk && !reset) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

   // First-word-fall-through read port: the head word is visible as soon as
   // it is written, and it reads as zero while nothing is queued.
   always_comb begin
      popData_o = empty_o ? '0 : mem_q[rdPtr_q];
      level_o   = level_q;
   end

endmodule

// File: rtl/ttl_bus_capture.sv
// ---------------------------------------------------------------------------
// TtlBusCapture (module ttl_bus_capture)
//
// Purpose:
//    Captures words from a remote tri-stated TTL bus whose driver is enabled
//    by the active-low, asynchronous strobe Gn. Each low window of Gn seen by
//    the synchronizer yields exactly one word: the last synchronized bus value
//    while the window was open. The word is queued in a FWFT FIFO on the
//    rising edge of the synchronized strobe.
//
// Parameters:
//    DATA_W    width of the captured bus
//    DEPTH     FIFO entries, power of two, at least 2
//    PULL_VAL  value a floating (z/x) bus bit resolves to in simulation
//
// Ports:
//    clk        single clock for all state
//    reset      synchronous active-high reset
//    Gn         asynchronous active-low drive enable of the remote driver
//    BUS        tri-stated data bus, may be z when not driven
//    out_data   FIFO head word (valid while out_valid is high)
//    out_valid  FIFO non-empty
//    out_ready  consumer accept; a pop happens when valid and ready are high
//    overflow   sticky flag, set when a capture was dropped on a full FIFO
//    level      current FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ttl_bus_capture #(
   parameter int   DATA_W   = 8,
   parameter int   DEPTH    = 4,
   parameter logic PULL_VAL = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     Gn,
   input  logic [DATA_W-1:0]        BUS,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   logic [DATA_W-1:0] busRes;
   logic              gMeta_q;
   logic              gS_q;
   logic              gPrev_q;
   logic [DATA_W-1:0] busMeta_q;
   logic [DATA_W-1:0] busS_q;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] hold_d;
   logic              overflow_q;
   logic              overflow_d;
   logic              rise;
   logic              popReq;
   logic              fifoFull;
   logic              fifoEmpty;

   // Floating-bus resolution. A bit that is neither a clean 0 nor a clean 1
   // (z when nobody drives, x on contention) is replaced by the pull value,
   // modelling the board pull resistor. On real silicon every bit is 0 or 1,
   // so this reduces to a plain pass-through.
   always_comb begin
      busRes = BUS;
      for (int i = 0; i < DATA_W; i++) begin
         if ((BUS[i] !== 1'b0) && (BUS[i] !== 1'b1)) begin
            busRes[i] = PULL_VAL;
         end
      end
   end

   // Two-flop synchronizers for the strobe and the bus, plus a registered copy
   // of the synchronized strobe for edge detection. The strobe path resets to
   // the idle (high) level and its previous copy does too, so releasing reset
   // can never look like a rising edge. Bus and strobe share the same delay,
   // which keeps the captured word aligned with the strobe that qualified it.
   always_ff @(posedge clk) begin
      if (reset) begin
         gMeta_q   <= 1'b1;
         gS_q      <= 1'b1;
         gPrev_q   <= 1'b1;
         busMeta_q <= '0;
         busS_q    <= '0;
      end else begin
         gMeta_q   <= Gn;
         gS_q      <= gMeta_q;
         gPrev_q   <= gS_q;
         busMeta_q <= busRes;
         busS_q    <= busS_q == busS_q ? busMeta_q : busMeta_q;
      end
   end

   // The hold register tracks the synchronized bus for as long as the
   // synchronized strobe is low and freezes once it goes high. A long window
   // therefore keeps the last value seen before the strobe rose. The rise
   // event pushes that frozen value exactly once per window. Overflow is
   // sticky: it records a rise that met a full FIFO with no pop freeing a
   // slot in the same cycle, and only reset clears it.
   always_comb begin
      rise       = gS_q && !gPrev_q;
      popReq     = out_ready && !fifoEmpty;
      hold_d     = gS_q ? hold_q : busS_q;
      overflow_d = overflow_q || (rise && fifoFull && !popReq);
   end

   // Capture and flag registers, cleared by the synchronous reset so that a
   // window open at reset time is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         overflow_q <= overflow_d;
      end
   end

   // Output queue. The rise event writes the hold register, so a word reaches
   // the head two clocks after the edge that first samples Gn high.
   ttl_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (rise),
      .pushData_i (hold_q),
      .pop_i      (popReq),
      .popData_o  (out_data),
      .level_o    (level),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty)
   );

   // Remaining outputs are direct views of internal state.
   always_comb begin
      out_valid = !fifoEmpty;
      overflow  = overflow_q;
   end

endmodule
